// File: rtl/hex_sched_pkg.sv
// Shared state type, 7-segment constants and BCD decode function for hex_display_scheduler.
// Segment vectors are [0:6] = a..g, active-low.
package hex_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;

    // Non-BCD nibbles (10..15) show nothing rather than hex glyphs.
    function automatic logic [0:6] bcd_to_seg(input logic [3:0] nibble);
        logic [0:6] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Registered BCD nibble to active-low 7-segment decoder, one per HEX digit.
module seg7_bcd_decode
    import hex_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       blank_i,
    input  logic [3:0] nibble_i,
    output logic [0:6] seg_o
);

    logic [0:6] seg_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q <= SEG_BLANK;
        end else begin
            seg_q <= blank_i ? SEG_BLANK : bcd_to_seg(nibble_i);
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin time-slicing of HEX3..HEX0 among NREQ BCD clients.
// Optional macro DISP_GAP_EN inserts a one-tick blank gap on handover to a different client.
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned SLOT_TICKS = 3
) (
    input  logic                     CLOCK_50Mhz,
    input  logic                     RESET,
    input  logic [NREQ-1:0]          REQ,
    input  logic [16*NREQ-1:0]       DIGITS,
    output logic [NREQ-1:0]          GNT,
    output logic [$clog2(NREQ)-1:0]  ACTIVE_ID,
    output logic                     SLOT_END,
    output logic [0:6]               HEX0,
    output logic [0:6]               HEX1,
    output logic [0:6]               HEX2,
    output logic [0:6]               HEX3
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned SW  = $clog2(SLOT_TICKS + 1);

    sched_state_e    state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic            slot_end_c;

    logic            tick;
    logic [IDW-1:0]  ptr_adv;
    logic [IDW-1:0]  arb_base;
    logic            arb_found;
    logic [IDW-1:0]  arb_id;
    logic            do_grant;

    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign ptr_adv  = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
    // At a slot end the search already starts past the outgoing client.
    assign arb_base = (state_q == ST_SHOW) ? ptr_adv : ptr_q;

    // First requester at or after arb_base, wrapping.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] idx_w;
        arb_found = 1'b0;
        arb_id    = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(arb_base) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IDW'(idx);
            if (!arb_found && REQ[idx_w]) begin
                arb_found = 1'b1;
                arb_id    = idx_w;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        gnt_d      = gnt_q;
        presc_d    = presc_q;
        slot_d     = slot_q;
        slot_end_c = 1'b0;
        do_grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_grant = arb_found;
            end
            ST_SHOW: begin
                if (!REQ[id_q] || (tick && (slot_q == SW'(SLOT_TICKS - 1)))) begin
                    slot_end_c = 1'b1;
                    ptr_d      = ptr_adv;
                    if (!arb_found) begin
                        state_d = ST_IDLE;
                        id_d    = '0;
                        gnt_d   = '0;
`ifdef DISP_GAP_EN
                    end else if (arb_id != id_q) begin
                        state_d = ST_GAP;
                        id_d    = '0;
                        gnt_d   = '0;
                        presc_d = '0;
                        slot_d  = '0;
`endif
                    end else begin
                        do_grant = 1'b1;
                    end
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        slot_d = slot_q + SW'(1);
                    end
                end
            end
`ifdef DISP_GAP_EN
            ST_GAP: begin
                if (tick) begin
                    if (arb_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every grant restarts the slot timing from zero.
        if (do_grant) begin
            state_d = ST_SHOW;
            id_d    = arb_id;
            gnt_d   = NREQ'(1) << arb_id;
            presc_d = '0;
            slot_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_50Mhz) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            presc_q <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            presc_q <= presc_d;
            slot_q  <= slot_d;
        end
    end

    assign GNT       = gnt_q;
    assign ACTIVE_ID = id_q;
    assign SLOT_END  = slot_end_c;

    // Live view of the granted client's digits; blank whenever nobody holds the grant.
    logic [15:0] client_digits [NREQ];
    logic [15:0] cur_digits;
    logic        disp_blank;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign client_digits[g] = DIGITS[16*g +: 16];
    end

    assign cur_digits = client_digits[id_q];
    assign disp_blank = (gnt_q == '0);

    seg7_bcd_decode u_dec0 (
        .clk_i    (CLOCK_50Mhz),
        .rst_i    (RESET),
        .blank_i  (disp_blank),
        .nibble_i (cur_digits[3:0]),
        .seg_o    (HEX0)
    );

    seg7_bcd_decode u_dec1 (
        .clk_i    (CLOCK_50Mhz),
        .rst_i    (RESET),
        .blank_i  (disp_blank),
        .nibble_i (cur_digits[7:4]),
        .seg_o    (HEX1)
    );

    seg7_bcd_decode u_dec2 (
        .clk_i    (CLOCK_50Mhz),
        .rst_i    (RESET),
        .blank_i  (disp_blank),
        .nibble_i (cur_digits[11:8]),
        .seg_o    (HEX2)
    );

    seg7_bcd_decode u_dec3 (
        .clk_i    (CLOCK_50Mhz),
        .rst_i    (RESET),
        .blank_i  (disp_blank),
        .nibble_i (cur_digits[15:12]),
        .seg_o    (HEX3)
    );

endmodule
